// File: rtl/shift_pkg.sv
// Shared types and constants for the shift_delay_ctrl delay line.
package shift_pkg;

  // FILL: collecting the first D samples since a flush; RUN: every accepted
  // sample pushes out the one accepted D samples earlier.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A delay of zero is meaningless for the delay line, so a load of 0 is
  // promoted to this value.
  localparam int unsigned MIN_DELAY = 1;

endpackage

// File: rtl/shift_delay_ctrl_if.sv
// Configuration, sample stream and status bundle of the delay line.
interface shift_delay_ctrl_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 3
);

  logic [ADDR_WIDTH-1:0] cfg_delay;
  logic                  cfg_load;
  logic                  ivalid;
  logic [WIDTH-1:0]      shiftin;
  logic                  ovalid;
  logic [WIDTH-1:0]      shiftout;
  logic [ADDR_WIDTH-1:0] fill_level;
  logic                  running;

  // Side that supplies samples and configuration.
  modport master (
    output cfg_delay, cfg_load, ivalid, shiftin,
    input  ovalid, shiftout, fill_level, running
  );

  // The delay line itself.
  modport slave (
    input  cfg_delay, cfg_load, ivalid, shiftin,
    output ovalid, shiftout, fill_level, running
  );

endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module sdp_ram #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  // NOTE: the array has no reset so it maps onto RAM macros; stale contents
  // are harmless because the controller never reads a slot it has not refilled.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port with one cycle of latency; holds its value when idle.
  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/shift_delay_ctrl.sv
// Programmable delay line: each accepted sample re-emerges D accepted samples
// later. Storage is a circular buffer; this module holds all control.
module shift_delay_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int ADDR_WIDTH    = 3,
  parameter int DEFAULT_DELAY = 4
) (
  input  logic             clock,
  input  logic             reset,
  shift_delay_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] delay_q, delay_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] load_delay;
  logic                  rd_en;
  logic                  wr_en;
  logic                  ovalid_q;
  logic [WIDTH-1:0]      rd_data;

  assign load_delay = (bus.cfg_delay == '0) ? ADDR_WIDTH'(MIN_DELAY) : bus.cfg_delay;
  assign wr_en      = bus.ivalid && !reset;
  // Slot written D accepted samples ago; wraps naturally modulo the depth.
  assign rd_addr    = wr_addr_q - delay_q;

  sdp_ram #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr_q),
    .wr_data (bus.shiftin),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Next-state, fill tracking and read issue.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    delay_d = delay_q;
    rd_en   = 1'b0;
    if (bus.cfg_load) begin
      // Flush: a sample arriving with the load is the first of the new fill.
      delay_d = load_delay;
      fill_d  = bus.ivalid ? ONE : '0;
      state_d = (bus.ivalid && load_delay == ONE) ? RUN : FILL;
    end else if (bus.ivalid) begin
      unique case (state_q)
        FILL: begin
          fill_d = fill_q + ONE;
          if (fill_q == delay_q - ONE) state_d = RUN;
        end
        RUN:     rd_en = 1'b1;
        default: state_d = FILL;
      endcase
    end
  end

  // State, configuration and write pointer registers; reset wins over all.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FILL;
      fill_q    <= '0;
      delay_q   <= ADDR_WIDTH'(DEFAULT_DELAY);
      wr_addr_q <= '0;
      ovalid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      delay_q  <= delay_d;
      ovalid_q <= rd_en;
      if (bus.ivalid) wr_addr_q <= wr_addr_q + ONE;
    end
  end

  assign bus.ovalid     = ovalid_q;
  assign bus.shiftout   = ovalid_q ? rd_data : '0;
  assign bus.fill_level = fill_q;
  assign bus.running    = (state_q == RUN);

endmodule

// File: tb/tb_shift_delay_ctrl.sv
// Self-checking bench for shift_delay_ctrl: directed scenarios with literal
// expectations, then random traffic, all compared against a queue model.
module tb_shift_delay_ctrl;

  localparam int WIDTH = 32;
  localparam int AW    = 3;
  localparam int DEF   = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_delay_ctrl_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

  shift_delay_ctrl #(
    .WIDTH         (WIDTH),
    .ADDR_WIDTH    (AW),
    .DEFAULT_DELAY (DEF)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: the list of samples accepted since the last flush.
  // Sample k (k >= D) must emerge one cycle later as sample k-D.
  logic [31:0] hist[$];
  int          cnt     = 0;
  int          d_model = DEF;
  bit          exp_ovalid = 1'b0;
  logic [31:0] exp_out    = '0;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    model_live = 1'b1;
    exp_ovalid = 1'b0;
    exp_out    = '0;
    if (rst) begin
      cnt     = 0;
      d_model = DEF;
      hist.delete();
    end else begin
      if (bus.cfg_load) begin
        d_model = (bus.cfg_delay == 0) ? 1 : int'(bus.cfg_delay);
        cnt     = 0;
        hist.delete();
      end
      if (bus.ivalid) begin
        if (cnt >= d_model) begin
          exp_ovalid = 1'b1;
          exp_out    = hist[cnt - d_model];
        end
        hist.push_back(bus.shiftin);
        cnt++;
      end
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("ovalid",     32'(bus.ovalid),     32'(exp_ovalid));
      check("shiftout",   bus.shiftout,        exp_out);
      check("fill_level", 32'(bus.fill_level), (cnt < d_model) ? cnt : d_model);
      check("running",    32'(bus.running),    32'(cnt >= d_model));
    end
  end

  // Apply one cycle of inputs and return at the following falling edge.
  task automatic step(input logic r, input logic ld, input logic [AW-1:0] dly,
                      input logic iv, input logic [31:0] din);
    rst           = r;
    bus.cfg_load  = ld;
    bus.cfg_delay = dly;
    bus.ivalid    = iv;
    bus.shiftin   = din;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state.
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    check("rst_ovalid",  32'(bus.ovalid),     0);
    check("rst_fill",    32'(bus.fill_level), 0);
    check("rst_running", 32'(bus.running),    0);

    // Continuous stream 1,2,3,... with the default delay of 4.
    for (int v = 1; v <= 19; v++) begin
      step(1'b0, 1'b0, '0, 1'b1, 32'(v));
      if (v == 4) begin
        check("fill_to_run",   32'(bus.running), 1);
        check("fill_no_out",   32'(bus.ovalid),  0);
      end
      if (v == 5) check("first_out", bus.shiftout, 1);
      if (v == 8) check("cont_out",  bus.shiftout, 4);
    end

    // Reload to delay 2 mid-stream together with sample 20.
    step(1'b0, 1'b1, 3'd2, 1'b1, 32'd20);
    check("load_suppress", 32'(bus.ovalid),     0);
    check("load_fill",     32'(bus.fill_level), 1);
    step(1'b0, 1'b0, '0, 1'b1, 32'd21);
    check("load2_quiet",   32'(bus.ovalid),  0);
    check("load2_running", 32'(bus.running), 1);
    step(1'b0, 1'b0, '0, 1'b1, 32'd22);
    check("load2_out", bus.shiftout, 20);

    // Delay 0 clamps to 1.
    step(1'b0, 1'b1, 3'd0, 1'b0, '0);
    check("d0_fill", 32'(bus.fill_level), 0);
    step(1'b0, 1'b0, '0, 1'b1, 32'd7);
    check("d0_running", 32'(bus.running), 1);
    step(1'b0, 1'b0, '0, 1'b1, 32'd8);
    check("d0_out", bus.shiftout, 7);

    // Reset mid-run dominates a simultaneous load and sample.
    step(1'b1, 1'b1, 3'd5, 1'b1, 32'd99);
    check("midrst_ovalid", 32'(bus.ovalid),     0);
    check("midrst_fill",   32'(bus.fill_level), 0);
    for (int v = 1; v <= 5; v++) begin
      step(1'b0, 1'b0, '0, 1'b1, 32'(v));
      if (v == 5) check("restart_out", bus.shiftout, 1);
    end

    // Alternating valid/idle: output stays contiguous, no duplicates.
    step(1'b1, 1'b0, '0, 1'b0, '0);
    for (int v = 1; v <= 8; v++) begin
      step(1'b0, 1'b0, '0, 1'b1, 32'(v));
      if (v == 6) check("gap_out", bus.shiftout, 2);
      step(1'b0, 1'b0, '0, 1'b0, $urandom);
      if (v == 6) check("gap_idle", 32'(bus.ovalid), 0);
    end

    // Maximum delay 7 across several pointer wraps.
    step(1'b0, 1'b1, 3'd7, 1'b0, '0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, '0, 1'b1, 32'(k + 1));
      if (k == 7)  check("d7_first", bus.shiftout, 1);
      if (k == 19) check("d7_last",  bus.shiftout, 13);
    end

    // Random traffic: gaps, reloads with any delay, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 29) == 0,
           AW'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 7,
           $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
